sram_port_arbiter: RTL and testbench

Two-master arbiter that shares a single SRAM-like memory port between the instruction-fetch requester and the data requester. The data requester is the EXE-stage load/store path. The block sits between the pipeline and the unified memory interface. It grants one master at a time and allows exactly one outstanding transaction. It routes the granted master's request fields to the slave and returns addr_ok, data_ok and rdata only to the owner.

---
 rtl/sram_port_arbiter_pkg.sv | 16 +
 rtl/sram_port_arbiter_pick.sv | 33 +++
 rtl/sram_port_arbiter.sv | 108 ++++++++++
 tb/tb_sram_port_arbiter.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/sram_port_arbiter_pkg.sv
// Shared encodings for the SRAM port arbiter.
// FSM state codes and owner IDs.
package sram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      SPA_IDLE = 2'd0,
      SPA_ADDR = 2'd1,
      SPA_DATA = 2'd2
   } spa_state_e;

   typedef enum logic {
      SPA_OWN_INST = 1'b0,
      SPA_OWN_DATA = 1'b1
   } spa_owner_e;

endpackage

// File: rtl/sram_port_arbiter_pick.sv
// spa_pick: combinational winner select from inst_req/data_req/last_owner.
// ARB_ROUND_ROBIN_EN selects alternating grants, otherwise data wins.
module spa_pick
   import sram_port_arbiter_pkg::*;
(
   input  logic       inst_req,
   input  logic       data_req,
   input  spa_owner_e last_owner,
   output spa_owner_e winner
);

`ifdef ARB_ROUND_ROBIN_EN
   always_comb begin
      winner = SPA_OWN_INST;
      if (inst_req && data_req) begin
         // contention: grant whoever did not win last time
         if (last_owner == SPA_OWN_DATA) winner = SPA_OWN_INST;
         else                            winner = SPA_OWN_DATA;
      end else if (data_req) begin
         winner = SPA_OWN_DATA;
      end
   end
`else
   logic unused_pick;
   assign unused_pick = inst_req ^ last_owner;

   always_comb begin
      winner = SPA_OWN_INST;
      if (data_req) winner = SPA_OWN_DATA;
   end
`endif

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between inst fetch and data masters, one txn
// outstanding. Optional macro ARB_ROUND_ROBIN_EN enables round-robin grant.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              inst_req,
   input  logic              inst_wr,
   input  logic [1:0]        inst_size,
   input  logic [3:0]        inst_wstrb,
   input  logic [ADDR_W-1:0] inst_addr,
   input  logic [DATA_W-1:0] inst_wdata,
   output logic              inst_addr_ok,
   output logic              inst_data_ok,
   output logic [DATA_W-1:0] inst_rdata,
   input  logic              data_req,
   input  logic              data_wr,
   input  logic [1:0]        data_size,
   input  logic [3:0]        data_wstrb,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_addr_ok,
   output logic              data_data_ok,
   output logic [DATA_W-1:0] data_rdata,
   output logic              sram_req,
   output logic              sram_wr,
   output logic [1:0]        sram_size,
   output logic [3:0]        sram_wstrb,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic              sram_addr_ok,
   input  logic              sram_data_ok,
   input  logic [DATA_W-1:0] sram_rdata
);

   spa_state_e state;
   spa_owner_e owner;
   spa_owner_e last_owner;
   spa_owner_e winner;

`ifdef ARB_ROUND_ROBIN_EN
   spa_owner_e last_q;
   assign last_owner = last_q;
`else
   assign last_owner = SPA_OWN_INST;
`endif

   spa_pick u_pick (
      .inst_req   (inst_req),
      .data_req   (data_req),
      .last_owner (last_owner),
      .winner     (winner)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= SPA_IDLE;
         owner <= SPA_OWN_INST;
`ifdef ARB_ROUND_ROBIN_EN
         last_q <= SPA_OWN_INST;
`endif
      end else begin
         case (state)
            SPA_IDLE: begin
               if (inst_req || data_req) begin
                  owner <= winner;
                  state <= SPA_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
                  last_q <= winner;
`endif
               end
            end
            SPA_ADDR: if (sram_addr_ok) state <= SPA_DATA;
            SPA_DATA: if (sram_data_ok) state <= SPA_IDLE;
            default:  state <= SPA_IDLE;
         endcase
      end
   end

   // reset also gates outputs so nothing leaks during the reset cycle
   logic in_addr;
   logic in_data;
   logic own_d;

   assign in_addr = resetn && (state == SPA_ADDR);
   assign in_data = resetn && (state == SPA_DATA);
   assign own_d   = (owner == SPA_OWN_DATA);

   assign sram_req   = in_addr;
   assign sram_wr    = in_addr && (own_d ? data_wr : inst_wr);
   assign sram_size  = in_addr ? (own_d ? data_size  : inst_size)  : '0;
   assign sram_wstrb = in_addr ? (own_d ? data_wstrb : inst_wstrb) : '0;
   assign sram_addr  = in_addr ? (own_d ? data_addr  : inst_addr)  : '0;
   assign sram_wdata = in_addr ? (own_d ? data_wdata : inst_wdata) : '0;

   assign inst_addr_ok = in_addr && !own_d && sram_addr_ok;
   assign data_addr_ok = in_addr &&  own_d && sram_addr_ok;
   assign inst_data_ok = in_data && !own_d && sram_data_ok;
   assign data_data_ok = in_data &&  own_d && sram_data_ok;

   assign inst_rdata = inst_data_ok ? sram_rdata : '0;
   assign data_rdata = data_data_ok ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: per-cycle vector table
// plus a hand-written contention sequence for grant order.
module tb_sram_port_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [3:0]  inst_wstrb;
   logic [31:0] inst_addr, inst_wdata;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        sram_req, sram_wr;
   logic [1:0]  sram_size;
   logic [3:0]  sram_wstrb;
   logic [31:0] sram_addr, sram_wdata;
   logic        sram_addr_ok, sram_data_ok;
   logic [31:0] sram_rdata;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
      .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
      .sram_wstrb(sram_wstrb), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_addr_ok(sram_addr_ok),
      .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata)
   );

   typedef struct {
      logic        rstn, ireq, dreq, dwr, aok, dok;
      logic [31:0] rd;
      logic        sreq, swr;
      logic [3:0]  swstrb;
      logic [31:0] saddr, swdata;
      logic        iaok, idok;
      logic [31:0] irdata;
      logic        daok, ddok;
      logic [31:0] drdata;
   } vec_t;

   vec_t v[24];

   function automatic vec_t mk(
      input logic rstn, ireq, dreq, dwr, aok, dok,
      input logic [31:0] rd,
      input logic sreq, swr, input logic [3:0] swstrb,
      input logic [31:0] saddr, swdata,
      input logic iaok, idok, input logic [31:0] irdata,
      input logic daok, ddok, input logic [31:0] drdata);
      vec_t r;
      r.rstn = rstn; r.ireq = ireq; r.dreq = dreq; r.dwr = dwr;
      r.aok = aok; r.dok = dok; r.rd = rd;
      r.sreq = sreq; r.swr = swr; r.swstrb = swstrb;
      r.saddr = saddr; r.swdata = swdata;
      r.iaok = iaok; r.idok = idok; r.irdata = irdata;
      r.daok = daok; r.ddok = ddok; r.drdata = drdata;
      return r;
   endfunction

   task automatic check(input string name,
                        input logic [139:0] act, input logic [139:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [139:0] pack_exp(input vec_t e);
      logic [1:0] sz;
      sz = e.sreq ? 2'd2 : 2'd0;
      return {e.sreq, e.swr, sz, e.swstrb, e.saddr, e.swdata,
              e.iaok, e.idok, e.irdata, e.daok, e.ddok, e.drdata};
   endfunction

   function automatic logic [139:0] pack_act();
      return {sram_req, sram_wr, sram_size, sram_wstrb, sram_addr,
              sram_wdata, inst_addr_ok, inst_data_ok, inst_rdata,
              data_addr_ok, data_data_ok, data_rdata};
   endfunction

   localparam logic [31:0] IA = 32'h1C00_0000;
   localparam logic [31:0] DA = 32'h0000_1000;
   localparam logic [31:0] DW = 32'hDEAD_BEEF;
   localparam logic [31:0] Z  = 32'h0;

   initial begin
      logic [1:0] grants[4];
      logic [1:0] want[4];

      inst_wr = 0; inst_size = 2; inst_wstrb = 0;
      inst_addr = IA; inst_wdata = 0;
      data_wr = 0; data_size = 2; data_wstrb = 4'h3;
      data_addr = DA; data_wdata = DW;
      resetn = 0; inst_req = 0; data_req = 0;
      sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = 0;

      //      rst ir dr dw ao do rd   sreq wr strb saddr swdata ia id ird  da dd drd
      v[0]  = mk(0,0,0,0,0,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[1]  = mk(1,1,0,0,0,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[2]  = mk(1,1,0,0,1,0,Z,           1,0,0,IA,Z,  1,0,Z,            0,0,Z);
      v[3]  = mk(1,0,0,0,0,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[4]  = mk(1,0,0,0,0,1,32'h0280_0000,0,0,0,Z,Z,  0,1,32'h0280_0000,0,0,Z);
      v[5]  = mk(1,0,0,0,0,1,32'hFFFF_FFFF,0,0,0,Z,Z,  0,0,Z,            0,0,Z);
      v[6]  = mk(1,0,0,0,1,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[7]  = mk(1,1,1,0,0,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[8]  = mk(1,1,1,0,1,0,Z,           1,0,3,DA,DW, 0,0,Z,            1,0,Z);
      v[9]  = mk(1,1,0,0,0,1,32'h1234_5678,0,0,0,Z,Z,  0,0,Z,            0,1,32'h1234_5678);
      v[10] = mk(1,1,0,0,0,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[11] = mk(1,1,0,0,1,0,Z,           1,0,0,IA,Z,  1,0,Z,            0,0,Z);
      v[12] = mk(1,0,0,0,0,1,32'hA5A5_A5A5,0,0,0,Z,Z,  0,1,32'hA5A5_A5A5,0,0,Z);
      v[13] = mk(1,0,1,1,0,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[14] = mk(1,0,1,1,0,0,Z,           1,1,3,DA,DW, 0,0,Z,            0,0,Z);
      v[15] = mk(1,0,1,1,0,0,Z,           1,1,3,DA,DW, 0,0,Z,            0,0,Z);
      v[16] = mk(1,0,1,1,0,0,Z,           1,1,3,DA,DW, 0,0,Z,            0,0,Z);
      v[17] = mk(1,0,1,1,1,0,Z,           1,1,3,DA,DW, 0,0,Z,            1,0,Z);
      v[18] = mk(1,0,0,0,0,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[19] = mk(1,0,0,0,0,1,Z,           0,0,0,Z,Z,   0,0,Z,            0,1,Z);
      v[20] = mk(1,1,0,0,0,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[21] = mk(1,1,0,0,1,0,Z,           1,0,0,IA,Z,  1,0,Z,            0,0,Z);
      v[22] = mk(0,0,0,0,0,0,Z,           0,0,0,Z,Z,   0,0,Z,            0,0,Z);
      v[23] = mk(1,0,0,0,0,1,32'h0000_0055,0,0,0,Z,Z,  0,0,Z,            0,0,Z);

      repeat (2) @(posedge clk);

      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         resetn = v[i].rstn; inst_req = v[i].ireq;
         data_req = v[i].dreq; data_wr = v[i].dwr;
         sram_addr_ok = v[i].aok; sram_data_ok = v[i].dok;
         sram_rdata = v[i].rd;
         #1;
         check($sformatf("vec%0d", i), pack_act(), pack_exp(v[i]));
      end

      // contention: both masters request continuously for 4 txns
`ifdef ARB_ROUND_ROBIN_EN
      want[0] = 2'b10; want[1] = 2'b01; want[2] = 2'b10; want[3] = 2'b01;
`else
      want[0] = 2'b10; want[1] = 2'b10; want[2] = 2'b10; want[3] = 2'b10;
`endif
      @(negedge clk);
      resetn = 0; inst_req = 0; data_req = 0; data_wr = 0;
      sram_addr_ok = 0; sram_data_ok = 0; sram_rdata = 0;
      @(negedge clk);
      resetn = 1; inst_req = 1; data_req = 1;
      for (int t = 0; t < 4; t++) begin
         @(negedge clk);
         sram_addr_ok = 1; sram_data_ok = 0;
         #1;
         grants[t] = {data_addr_ok, inst_addr_ok};
         check($sformatf("rr_grant%0d", t), {138'd0, grants[t]},
               {138'd0, want[t]});
         @(negedge clk);
         sram_addr_ok = 0; sram_data_ok = 1; sram_rdata = 32'h100 + t;
         #1;
         check($sformatf("rr_dataok%0d", t),
               {106'd0, data_data_ok, inst_data_ok, inst_rdata | data_rdata},
               {106'd0, want[t], 32'h100 + t});
         @(negedge clk);
         sram_data_ok = 0;
         #1;
         check($sformatf("rr_bubble%0d", t), {139'd0, sram_req}, 140'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
